fifo_scd_ext: RTL and testbench

Parametrised single-clock FIFO: the next generation of the team's `fifo_scd`. Adds selectable standard/first-word-fall-through read mode, fill count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses and a synchronous flush. It sits between a producer and a consumer in the same clock domain, as a drop-in replacement where the added status is needed.

---
 rtl/fifo_scd_pkg.sv | 12 +
 rtl/fifo_scd_mem.sv | 24 ++
 rtl/fifo_scd_ext.sv | 107 ++++++++++
 tb/tb_fifo_scd_ext.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_scd_pkg.sv
// Shared constants and helpers for the fifo_scd family.
package fifo_scd_pkg;

  localparam int FIFO_DW_DEF    = 8;
  localparam int FIFO_DEPTH_DEF = 4;

  // One extra pointer bit distinguishes full from empty when the address bits match.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_scd_mem.sv
// FIFO storage: synchronous write, asynchronous read.
module fifo_scd_mem
  import fifo_scd_pkg::*;
#(
  parameter int DW    = FIFO_DW_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_scd_ext.sv
// Single-clock FIFO with standard/FWFT read, fill count, thresholds,
// overflow/underflow pulses and synchronous flush.
module fifo_scd_ext
  import fifo_scd_pkg::*;
#(
  parameter int DW        = FIFO_DW_DEF,
  parameter int DEPTH     = FIFO_DEPTH_DEF,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    we,
  input  logic [DW-1:0]           din,
  input  logic                    re,
  output logic [DW-1:0]           dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [ptr_w(DEPTH)-1:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_scd_ext: DEPTH must be a power of 2 and at least 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("fifo_scd_ext: AFULL_TH must lie in 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_scd_ext: AEMPTY_TH must lie in 0..DEPTH-1");
  end

  logic [PW-1:0] r_wp, r_rp, w_count;
  logic          w_full, w_empty, w_rd_acc, w_wr_acc, w_mem_we;
  logic [DW-1:0] w_rdata;
  logic          r_ovf, r_udf;

  assign w_count  = r_wp - r_rp;
  assign w_empty  = (r_wp == r_rp);
  assign w_full   = (r_wp[PW-1] != r_rp[PW-1]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  // A read in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign w_rd_acc = re && !w_empty;
  assign w_wr_acc = we && (!w_full || re);
  assign w_mem_we = w_wr_acc && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else if (clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_wr_acc) r_wp <= r_wp + PW'(1);
      if (w_rd_acc) r_rp <= r_rp + PW'(1);
      r_ovf <= we && w_full && !re;
      r_udf <= re && w_empty;
    end
  end

  fifo_scd_mem #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wp[AW-1:0]),
    .i_wdata (din),
    .i_raddr (r_rp[AW-1:0]),
    .o_rdata (w_rdata)
  );

  if (FWFT != 0) begin : g_fwft
    assign dout = w_empty ? '0 : w_rdata;
  end else begin : g_std
    logic [DW-1:0] r_dout;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_dout <= '0;
      else if (clr)      r_dout <= '0;
      else if (w_rd_acc) r_dout <= w_rdata;
    end
    assign dout = r_dout;
  end

  assign count        = w_count;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_count >= AF_TH);
  assign almost_empty = (w_count <= AE_TH);
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_scd_ext.sv
// Bench: standard and FWFT instances share stimulus; a queue model predicts both.
module tb_fifo_scd_ext;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n, clr, we, re;
  logic [DW-1:0] din;

  logic [DW-1:0] s_dout, f_dout;
  logic s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] s_count, f_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_scd_ext #(.DW(DW), .DEPTH(DEPTH), .FWFT(0), .AFULL_TH(3), .AEMPTY_TH(1)) dut_std (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .din(din), .re(re),
    .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf)
  );

  fifo_scd_ext #(.DW(DW), .DEPTH(DEPTH), .FWFT(1), .AFULL_TH(3), .AEMPTY_TH(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr(clr), .we(we), .din(din), .re(re),
    .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf)
  );

  // Model: contents as a queue, plus the registered read word and pulse flags.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic m_ovf, m_udf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else if (clr) begin
      q.delete(); m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      automatic bit is_full  = (q.size() == DEPTH);
      automatic bit is_empty = (q.size() == 0);
      automatic bit rd = re && !is_empty;
      automatic bit wr = we && (!is_full || re);
      m_ovf = we && is_full && !re;
      m_udf = re && is_empty;
      if (rd) m_dout = q.pop_front();
      if (wr) q.push_back(din);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    automatic int n = q.size();
    automatic logic [DW-1:0] fw = (n > 0) ? q[0] : '0;
    chk("std_count", 32'(s_count), 32'(n));
    chk("std_full",  32'(s_full),  32'(n == DEPTH));
    chk("std_empty", 32'(s_empty), 32'(n == 0));
    chk("std_afull", 32'(s_af),    32'(n >= 3));
    chk("std_aempty",32'(s_ae),    32'(n <= 1));
    chk("std_ovf",   32'(s_ovf),   32'(m_ovf));
    chk("std_udf",   32'(s_udf),   32'(m_udf));
    chk("std_dout",  32'(s_dout),  32'(m_dout));
    chk("fw_count",  32'(f_count), 32'(n));
    chk("fw_full",   32'(f_full),  32'(n == DEPTH));
    chk("fw_empty",  32'(f_empty), 32'(n == 0));
    chk("fw_afull",  32'(f_af),    32'(n >= 3));
    chk("fw_aempty", 32'(f_ae),    32'(n <= 1));
    chk("fw_ovf",    32'(f_ovf),   32'(m_ovf));
    chk("fw_udf",    32'(f_udf),   32'(m_udf));
    chk("fw_dout",   32'(f_dout),  32'(fw));
  endtask

  // Called at a falling edge: drive, take one rising edge, check at the next falling edge.
  task automatic tick(input logic i_we, input logic i_re, input logic [DW-1:0] i_din,
                      input logic i_clr = 1'b0);
    we = i_we; re = i_re; din = i_din; clr = i_clr;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0; re = 1'b0; clr = 1'b0;
    compare_model();
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; we = 1'b0; re = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_model();
    chk("rst_empty",  32'(s_empty), 32'd1);
    chk("rst_aempty", 32'(s_ae),    32'd1);
    chk("rst_count",  32'(s_count), 32'd0);
    chk("rst_dout",   32'(s_dout),  32'h00);
    chk("rst_full",   32'(s_full),  32'd0);

    // Fill 0x01..0x04
    for (int i = 1; i <= 4; i++) tick(1'b1, 1'b0, DW'(i));
    chk("fill_full",  32'(s_full),  32'd1);
    chk("fill_count", 32'(s_count), 32'd4);
    chk("fill_afull", 32'(s_af),    32'd1);
    chk("fill_fwdout",32'(f_dout),  32'h01);

    // Overflow: 0x05 rejected
    tick(1'b1, 1'b0, 8'h05);
    chk("ovf_pulse", 32'(s_ovf),   32'd1);
    chk("ovf_count", 32'(s_count), 32'd4);
    tick(1'b0, 1'b0, 8'h00);
    chk("ovf_clear", 32'(s_ovf),   32'd0);

    // Drain
    for (int i = 1; i <= 4; i++) begin
      tick(1'b0, 1'b1, 8'h00);
      chk("drain_dout", 32'(s_dout), 32'(i));
    end
    chk("drain_empty", 32'(s_empty), 32'd1);

    // Underflow
    tick(1'b0, 1'b1, 8'h00);
    chk("udf_pulse", 32'(s_udf),  32'd1);
    chk("udf_dout",  32'(s_dout), 32'h04);
    tick(1'b0, 1'b0, 8'h00);
    chk("udf_clear", 32'(s_udf),  32'd0);

    // Simultaneous read/write while full
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'h21 + 8'(i));
    tick(1'b1, 1'b1, 8'hAA);
    chk("rw_full_dout",  32'(s_dout),  32'h21);
    chk("rw_full_count", 32'(s_count), 32'd4);
    chk("rw_full_ovf",   32'(s_ovf),   32'd0);
    tick(1'b0, 1'b1, 8'h00); chk("rw_rd1", 32'(s_dout), 32'h22);
    tick(1'b0, 1'b1, 8'h00); chk("rw_rd2", 32'(s_dout), 32'h23);
    tick(1'b0, 1'b1, 8'h00); chk("rw_rd3", 32'(s_dout), 32'h24);
    tick(1'b0, 1'b1, 8'h00); chk("rw_rd4", 32'(s_dout), 32'hAA);

    // FWFT fall-through
    tick(1'b1, 1'b0, 8'h10);
    chk("fwft_show",  32'(f_dout),  32'h10);
    tick(1'b0, 1'b1, 8'h00);
    chk("fwft_after", 32'(f_dout),  32'h00);
    chk("fwft_empty", 32'(f_empty), 32'd1);

    // Read and write together while empty: only the write lands
    tick(1'b1, 1'b1, 8'h55);
    chk("rw_empty_count", 32'(s_count), 32'd1);
    chk("rw_empty_udf",   32'(s_udf),   32'd1);
    tick(1'b0, 1'b1, 8'h00);
    chk("rw_empty_rd",    32'(s_dout),  32'h55);

    // Ten write/read pairs wrap the pointers
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b0, 8'h40 + 8'(i));
      tick(1'b0, 1'b1, 8'h00);
      chk("wrap_dout", 32'(s_dout), 32'(8'h40 + 8'(i)));
    end
    // Two-deep overlap across the wrap
    tick(1'b1, 1'b0, 8'h61);
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b1, 8'h62 + 8'(i));
    chk("overlap_dout", 32'(s_dout), 32'h66);

    // Flush with a concurrent write
    tick(1'b1, 1'b0, 8'h70);
    tick(1'b1, 1'b0, 8'h77, 1'b1);
    chk("clr_count", 32'(s_count), 32'd0);
    chk("clr_dout",  32'(s_dout),  32'h00);
    chk("clr_empty", 32'(s_empty), 32'd1);
    chk("clr_ovf",   32'(s_ovf),   32'd0);

    // Asynchronous reset mid-fill
    tick(1'b1, 1'b0, 8'h81);
    tick(1'b1, 1'b0, 8'h82);
    tick(1'b0, 1'b1, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count",  32'(s_count), 32'd0);
    chk("arst_empty",  32'(s_empty), 32'd1);
    chk("arst_aempty", 32'(s_ae),    32'd1);
    chk("arst_dout",   32'(s_dout),  32'h00);
    chk("arst_fwdout", 32'(f_dout),  32'h00);
    compare_model();
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 8'h90);
    chk("post_rst_fw", 32'(f_dout), 32'h90);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
